// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state types and funct3 decode helpers for the RV32M sequencer
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_e;

  function automatic logic is_div(md_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(md_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(md_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  // MUL and DIV/DIVU take the low half of the accumulator, the rest the high half
  function automatic logic is_lo_result(md_op_e op);
    return op inside {OP_MUL, OP_DIV, OP_DIVU};
  endfunction
endpackage

// File: rtl/md_step.sv
// md_step: one radix-2 iteration; shift-add multiply or restoring divide on a
// 2*XLEN accumulator ({product_hi, multiplier} or {remainder, dividend/quotient})
module md_step #(
  parameter int XLEN = 32
) (
  input  logic              i_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_acc
);
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_t;
  logic            w_ge;
  logic [XLEN-1:0] w_rem;
  assign w_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_b} : '0);
  assign w_t   = i_acc[2*XLEN-1:XLEN-1];
  assign w_ge  = w_t >= {1'b0, i_b};
  // when w_t >= divisor the true difference is below the divisor, so XLEN bits suffice
  assign w_rem = w_t[XLEN-1:0] - i_b;
  assign o_acc = !i_div ? {w_sum, i_acc[XLEN-1:1]} :
                 w_ge   ? {w_rem, i_acc[XLEN-2:0], 1'b1} :
                          {w_t[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer with pipeline stall request.
// MULDIV_EARLY_OUT_EN: finish zero-operand / divide-by-zero / overflow cases straight from accept.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);
  md_state_e         r_state;
  md_op_e            r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_fix;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  md_op_e            w_op;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_accept;
  logic              w_early;
  logic [XLEN-1:0]   w_early_res;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_fixed;
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;

  assign w_op     = md_op_e'(funct3);
  assign w_a_neg  = is_signed_a(w_op) & src_a[XLEN-1];
  assign w_b_neg  = is_signed_b(w_op) & src_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -src_a : src_a;
  assign w_b_mag  = w_b_neg ? -src_b : src_b;
  assign w_accept = start & (r_state == IDLE) & ~flush;

`ifdef MULDIV_EARLY_OUT_EN
  logic w_b_zero;
  logic w_ovf;
  assign w_b_zero    = ~|src_b;
  assign w_ovf       = (w_op == OP_DIV || w_op == OP_REM) &&
                       src_a == {1'b1, {(XLEN-1){1'b0}}} && &src_b;
  assign w_early     = is_div(w_op) ? (w_b_zero | w_ovf) : (~|src_a | w_b_zero);
  assign w_early_res = !is_div(w_op) ? '0 :
                       w_b_zero      ? (is_lo_result(w_op) ? '1 : src_a) :
                                       (is_lo_result(w_op) ? src_a : '0);
`else
  assign w_early     = 1'b0;
  assign w_early_res = '0;
`endif

  md_step #(.XLEN(XLEN)) u_step (
    .i_div (is_div(r_op)),
    .i_acc (r_acc),
    .i_b   (r_b),
    .o_acc (w_acc_nxt)
  );

  assign w_hi = r_acc[2*XLEN-1:XLEN];
  assign w_lo = r_acc[XLEN-1:0];
  // divide-by-zero leaves the dividend magnitude as remainder, so only the quotient needs overriding
  assign w_fixed = is_div(r_op) ?
                   {(r_neg_r ? -w_hi : w_hi),
                    (~|r_b ? {XLEN{1'b1}} : (r_neg_q ? -w_lo : w_lo))} :
                   (r_neg_q ? -r_acc : r_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_fix    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_op    <= w_op;
          r_cnt   <= '0;
          r_acc   <= {{XLEN{1'b0}}, w_a_mag};
          r_b     <= w_b_mag;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_fix   <= 1'b0;
          if (w_early) begin
            r_state  <= DONE;
            r_done   <= 1'b1;
            r_result <= w_early_res;
          end else begin
            r_state <= CALC;
            r_busy  <= 1'b1;
          end
        end
        CALC: if (flush) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(XLEN - 1)) r_state <= FIX;
        end
        // two phases: sign correction first, then result select
        FIX: if (flush) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else if (!r_fix) begin
          r_fix <= 1'b1;
          r_acc <= w_fixed;
        end else begin
          r_result <= is_lo_result(r_op) ? w_lo : w_hi;
          r_state  <= DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign stall  = r_busy | w_accept;
endmodule
